slow_spi_slave: RTL

Slow-FPGA end of the carrier-to-slow-FPGA control link. It receives 42-bit register-write frames from `panda_slowctrl` on a master-clocked serial line and presents them as single-cycle write strobes. It also transmits 42-bit readback frames to `panda_slowctrl` on a second, slave-clocked serial line. It sits between the slow-FPGA register bank and the link pins, and runs entirely in the slow-FPGA clock domain.

---
 rtl/slow_spi_pkg.sv | 17 +
 rtl/slow_spi_sync.sv | 32 +++
 rtl/slow_spi_slave.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/slow_spi_pkg.sv
// Shared frame geometry and transmitter state encoding for the slow-FPGA
// control link.
package slow_spi_pkg;

    localparam int FRAME_BITS = 42;
    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int BIT_W      = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/slow_spi_sync.sv
// Two-flop synchronizer for the incoming sclk/data pair, with a registered
// sclk rising-edge flag and the data bit delayed to line up with that flag.
module slow_spi_sync (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic sclk_i,
    input  logic dat_i,
    output logic rise_o,
    output logic dat_o
);

    logic [2:0] sclk_r;
    logic [2:0] dat_r;
    logic       rise_r;

    // Sync chains reset to the idle line levels so release never shows an edge.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            sclk_r <= 3'b111;
            dat_r  <= 3'b000;
            rise_r <= 1'b0;
        end else begin
            sclk_r <= {sclk_r[1:0], sclk_i};
            dat_r  <= {dat_r[1:0], dat_i};
            rise_r <= sclk_r[1] & ~sclk_r[2];
        end
    end

    assign rise_o = rise_r;
    assign dat_o  = dat_r[2];

endmodule

// File: rtl/slow_spi_slave.sv
// Slow-FPGA end of the control link: master-clocked register-write receiver
// and slave-clocked readback transmitter, both in the clk_i domain.
module slow_spi_slave
    import slow_spi_pkg::*;
#(
    parameter int CLK_DIV = 10,
    parameter int TIMEOUT = 256,
    parameter int GAP     = 32
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    output logic [ADDR_W-1:0] wr_adr_o,
    output logic [DATA_W-1:0] wr_dat_o,
    output logic              wr_stb_o,
    output logic              rx_err_o,
    input  logic              tx_req_i,
    input  logic [ADDR_W-1:0] tx_adr_i,
    input  logic [DATA_W-1:0] tx_dat_i,
    output logic              busy_o,
    input  logic              spi_sclk_i,
    input  logic              spi_dat_i,
    output logic              spi_sclk_o,
    output logic              spi_dat_o
);

    localparam int TO_W    = $clog2(TIMEOUT + 1);
    localparam int CNT_MAX = (CLK_DIV > GAP) ? CLK_DIV : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic                  sclk_rise_s;
    logic                  rx_bit_s;
    logic [FRAME_BITS-1:0] rx_word_s;
    logic [FRAME_BITS-2:0] rx_shift_r;
    logic [BIT_W-1:0]      rx_cnt_r;
    logic [TO_W-1:0]       to_cnt_r;
    logic [ADDR_W-1:0]     wr_adr_r;
    logic [DATA_W-1:0]     wr_dat_r;
    logic                  wr_stb_r;
    logic                  rx_err_r;

    tx_state_e             tx_state_r, tx_state_s;
    logic [CNT_W-1:0]      tx_cnt_r, tx_cnt_s;
    logic [BIT_W-1:0]      tx_bit_r, tx_bit_s;
    logic [FRAME_BITS-1:0] tx_shift_r, tx_shift_s;
    logic                  tx_sclk_r;
    logic                  tx_dat_r;
    logic                  busy_r;

    slow_spi_sync u_sync (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .sclk_i   (spi_sclk_i),
        .dat_i    (spi_dat_i),
        .rise_o   (sclk_rise_s),
        .dat_o    (rx_bit_s)
    );

    // The final bit is taken straight from the sync stage so the strobe
    // leaves one register after the edge flag.
    assign rx_word_s = {rx_shift_r, rx_bit_s};

    // Receive shifter, bit counter and partial-frame timeout.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rx_shift_r <= '0;
            rx_cnt_r   <= BIT_W'(0);
            to_cnt_r   <= TO_W'(0);
            wr_adr_r   <= ADDR_W'(0);
            wr_dat_r   <= DATA_W'(0);
            wr_stb_r   <= 1'b0;
            rx_err_r   <= 1'b0;
        end else begin
            wr_stb_r <= 1'b0;
            rx_err_r <= 1'b0;
            if (sclk_rise_s) begin
                rx_shift_r <= rx_word_s[FRAME_BITS-2:0];
                to_cnt_r   <= TO_W'(0);
                if (rx_cnt_r == BIT_W'(FRAME_BITS - 1)) begin
                    rx_cnt_r <= BIT_W'(0);
                    wr_stb_r <= 1'b1;
                    wr_adr_r <= rx_word_s[FRAME_BITS-1 -: ADDR_W];
                    wr_dat_r <= rx_word_s[DATA_W-1:0];
                end else begin
                    rx_cnt_r <= rx_cnt_r + BIT_W'(1);
                end
            end else if (rx_cnt_r != BIT_W'(0)) begin
                if (to_cnt_r == TO_W'(TIMEOUT - 1)) begin
                    to_cnt_r <= TO_W'(0);
                    rx_cnt_r <= BIT_W'(0);
                    rx_err_r <= 1'b1;
                end else begin
                    to_cnt_r <= to_cnt_r + TO_W'(1);
                end
            end else begin
                to_cnt_r <= TO_W'(0);
            end
        end
    end

    // Transmit FSM next-state: bit timing, bit index and frame shifter.
    always_comb begin
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r;
        tx_bit_s   = tx_bit_r;
        tx_shift_s = tx_shift_r;
        case (tx_state_r)
            ST_IDLE: begin
                if (tx_req_i) begin
                    tx_state_s = ST_LOW;
                    tx_cnt_s   = CNT_W'(0);
                    tx_bit_s   = BIT_W'(0);
                    tx_shift_s = {tx_adr_i, tx_dat_i};
                end else begin
                    tx_state_s = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (tx_cnt_r == CNT_W'(CLK_DIV - 1)) begin
                    tx_state_s = ST_HIGH;
                    tx_cnt_s   = CNT_W'(0);
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (tx_cnt_r == CNT_W'(CLK_DIV - 1)) begin
                    tx_cnt_s = CNT_W'(0);
                    if (tx_bit_r == BIT_W'(FRAME_BITS - 1)) begin
                        tx_state_s = ST_GAP;
                    end else begin
                        tx_state_s = ST_LOW;
                        tx_bit_s   = tx_bit_r + BIT_W'(1);
                        tx_shift_s = {tx_shift_r[FRAME_BITS-2:0], 1'b0};
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (tx_cnt_r == CNT_W'(GAP - 1)) begin
                    tx_state_s = ST_IDLE;
                    tx_cnt_s   = CNT_W'(0);
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                tx_state_s = ST_IDLE;
                tx_cnt_s   = CNT_W'(0);
            end
        endcase
    end

    // Transmit state register; line outputs are registered from the next state
    // so sclk and busy move in the cycle after a request is taken.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            tx_state_r <= ST_IDLE;
            tx_cnt_r   <= CNT_W'(0);
            tx_bit_r   <= BIT_W'(0);
            tx_shift_r <= '0;
            tx_sclk_r  <= 1'b1;
            tx_dat_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_bit_r   <= tx_bit_s;
            tx_shift_r <= tx_shift_s;
            tx_sclk_r  <= (tx_state_s != ST_LOW);
            tx_dat_r   <= ((tx_state_s == ST_LOW) || (tx_state_s == ST_HIGH)) ?
                          tx_shift_s[FRAME_BITS-1] : 1'b0;
            busy_r     <= (tx_state_s != ST_IDLE);
        end
    end

    assign wr_adr_o   = wr_adr_r;
    assign wr_dat_o   = wr_dat_r;
    assign wr_stb_o   = wr_stb_r;
    assign rx_err_o   = rx_err_r;
    assign busy_o     = busy_r;
    assign spi_sclk_o = tx_sclk_r;
    assign spi_dat_o  = tx_dat_r;

endmodule
